pdm_capture_controller: RTL and testbench
=========================================

// Module: pdm_capture_controller
// PURPOSE
//   Sequences one microphone capture: generates the PDM mic clock, flushes the
//   decimation chain, discards warm-up samples, then forwards exactly CAPTURE_LEN
//   8-bit PCM samples from the down-sample stage to a ready/valid consumer
//   (SPI/FIFO readout). Sits between the decimator output and the readout path.
// PARAMETERS
//   CLK_DIV      4    clk cycles per mic_clk period; even, >= 2
//   WARMUP_LEN   16   decimated samples dropped after start (mic/filter settling); >= 0
//   CAPTURE_LEN  1024 samples forwarded per capture; >= 1
//   CNT_W        16   width of sample_count; 2**CNT_W > CAPTURE_LEN
// PORTS
//   clk            in   1      system clock
//   rst            in   1      synchronous reset, active-high
//   start          in   1      1-cycle request to begin a capture (ignored while busy)
//   abort          in   1      terminate capture immediately
//   in_valid       in   1      decimated sample strobe from down-sample stage
//   in_data        in   8      decimated sample (offset-binary PCM)
//   mic_clk        out  1      PDM microphone clock
//   chain_flush    out  1      held high to clear the decimation chain
//   m_valid        out  1      output sample valid
//   m_data         out  8      output sample
//   m_ready        in   1      consumer accepts when m_valid & m_ready
//   busy           out  1      high in any state other than IDLE
//   done           out  1      1-cycle pulse at normal capture completion
//   overflow       out  1      sticky: a sample was lost because the output was full
//   sample_count   out  CNT_W  samples loaded into the output register this capture
// BEHAVIOUR
//   Reset: state=IDLE; mic_clk=0, chain_flush=0, m_valid=0, m_data=0, busy=0,
//     done=0, overflow=0, sample_count=0, all internal counters 0.
//   FSM: IDLE -> FLUSH -> WARMUP -> CAPTURE -> DRAIN -> IDLE.
//   IDLE: mic_clk held 0. start=1 -> FLUSH; clears overflow and sample_count.
//   FLUSH: chain_flush=1 for exactly CLK_DIV cycles, mic_clk running; then WARMUP
//     (CAPTURE if WARMUP_LEN=0). in_valid is ignored while in FLUSH.
//   WARMUP: count in_valid; after WARMUP_LEN strobes -> CAPTURE. Dropped samples
//     never appear on m_valid.
//   CAPTURE: on in_valid: if output register empty, or draining this cycle
//     (m_valid & m_ready), load in_data, m_valid=1 next cycle, sample_count++;
//     otherwise drop the sample, set overflow, do not count it. When sample_count
//     reaches CAPTURE_LEN -> DRAIN; further in_valid ignored.
//   DRAIN: mic_clk stopped (0); wait until m_valid=0 (last sample taken), then
//     done=1 for one cycle coincident with return to IDLE.
//   mic_clk: free counter 0..CLK_DIV-1 while running; mic_clk=1 for counts
//     >= CLK_DIV/2. Counter restarts at 0 on entry to FLUSH, so first rising edge
//     occurs CLK_DIV/2 cycles after start.
//   Output handshake: m_data stable while m_valid & !m_ready; m_valid drops the
//     cycle after acceptance unless a new sample is loaded in the same cycle.
//   Latency: in_valid at cycle t -> m_valid at t+1 (loaded case).
//   abort (any state, highest priority after rst): next cycle state=IDLE,
//     m_valid=0, mic_clk=0, chain_flush=0, no done pulse; overflow and
//     sample_count retain values for inspection.
//   start and abort same cycle: abort wins. start while busy: ignored.
//   rst mid-capture: identical to reset values; in-flight sample discarded.
// STRUCTURE
//   Package pdm_pkg: typedef enum logic [2:0] capture_state_t {IDLE, FLUSH,
//     WARMUP, CAPTURE, DRAIN}; typedef logic [7:0] pcm8_t.
//   Sub-module pdm_clk_gen (CLK_DIV): en/restart in, mic_clk out, counter inside.
//   FSM, warm-up/capture counters and 1-entry output register in top module.
// TESTING (CLK_DIV=4, WARMUP_LEN=2, CAPTURE_LEN=4 unless noted)
//   1 Normal: start, in_valid every 8 cycles with 0x10,0x11..0x15, m_ready=1
//     -> 0x12..0x15 out in order, done once, sample_count=4, overflow=0.
//   2 Backpressure: m_ready=0 during capture, two in_valid strobes -> first held
//     stable on m_data, second dropped, overflow=1, sample_count=1.
//   3 Drain wait: last sample loaded with m_ready=0 for 10 cycles -> busy stays 1,
//     done only after acceptance, mic_clk=0 during DRAIN.
//   4 Abort in CAPTURE after 2 samples -> IDLE next cycle, m_valid=0, no done,
//     sample_count=2; subsequent start clears it and captures 4 again.
//   5 Clocking: after start, chain_flush high exactly 4 cycles; mic_clk period 4,
//     duty 50%, first rise 2 cycles after start; start while busy has no effect.
//   6 rst asserted mid-WARMUP -> all outputs at reset values next cycle;
//     WARMUP_LEN=0 build goes FLUSH -> CAPTURE directly.

Source files
------------

// File: rtl/pdm_capture_controller_pkg.sv
// Shared types for the PDM capture controller: FSM state encoding and PCM sample type.
package pdm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WARMUP,
    CAPTURE,
    DRAIN
  } capture_state_t;

  typedef logic [7:0] pcm8_t;

  // The mic clock only toggles while the decimation chain is being fed.
  function automatic logic is_running(capture_state_t s);
    return (s == FLUSH) || (s == WARMUP) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/pdm_capture_controller_if.sv
// Sample stream bundle: decimator strobe in, ready/valid sample out to the readout path.
interface pdm_capture_controller_if;
  import pdm_pkg::*;

  logic  in_valid;
  pcm8_t in_data;
  logic  m_valid;
  pcm8_t m_data;
  logic  m_ready;

  // master: the capture controller; slave: the decimator/consumer side
  modport master (input in_valid, input in_data, input m_ready,
                  output m_valid, output m_data);
  modport slave  (output in_valid, output in_data, output m_ready,
                  input m_valid, input m_data);
endinterface

// File: rtl/pdm_capture_controller_clk_gen.sv
// PDM microphone clock divider: 50% duty, phase restarted at the start of each capture.
module pdm_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic mic_clk
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mic_clk_q, mic_clk_d;

  always_comb begin
    cnt_d     = '0;
    mic_clk_d = 1'b0;
    if (en && !restart) begin
      cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
    // Registered output so the mic sees a glitch-free clock.
    mic_clk_d = en && (cnt_d >= CW'(CLK_DIV / 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      mic_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mic_clk_q <= mic_clk_d;
    end
  end

  assign mic_clk = mic_clk_q;

endmodule

// File: rtl/pdm_capture_controller.sv
// Sequences one mic capture: flush, warm-up discard, then forwards CAPTURE_LEN samples
// through a one-entry ready/valid output register.
module pdm_capture_controller
  import pdm_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int WARMUP_LEN  = 16,
  parameter int CAPTURE_LEN = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  pdm_capture_controller_if.master bus,
  output logic                     mic_clk,
  output logic                     chain_flush,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [CNT_W-1:0]         sample_count
);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LEN    = CNT_W'(CAPTURE_LEN);

  capture_state_t   state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             m_valid_q, m_valid_d;
  pcm8_t            m_data_q, m_data_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             pop;

  assign pop = m_valid_q && bus.m_ready;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    if (pop) m_valid_d = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      m_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FLUSH;
            phase_d = '0;
            ovf_d   = 1'b0;
            count_d = '0;
          end
        end
        FLUSH: begin
          if (phase_q == FLUSH_LAST) begin
            phase_d = '0;
            state_d = (WARMUP_LEN == 0) ? CAPTURE : WARMUP;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        WARMUP: begin
          if (bus.in_valid) begin
            if (phase_q == WARM_LAST) state_d = CAPTURE;
            else                      phase_d = phase_q + 1'b1;
          end
        end
        CAPTURE: begin
          // A slot frees up if the register is empty or being emptied this cycle.
          if (bus.in_valid) begin
            if (!m_valid_q || pop) begin
              m_valid_d = 1'b1;
              m_data_d  = bus.in_data;
              count_d   = count_q + 1'b1;
              if (count_d == CAP_LEN) state_d = DRAIN;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!m_valid_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (is_running(state_d)),
    .restart ((state_q == IDLE) && (state_d == FLUSH)),
    .mic_clk (mic_clk)
  );

  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign chain_flush  = (state_q == FLUSH);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_pdm_capture_controller.sv
// Bench for pdm_capture_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_pdm_capture_controller;
  import pdm_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int WL      = 2;
  localparam int CL      = 4;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  logic mic_clk, chain_flush, busy, done, overflow;
  logic [CNT_W-1:0] sample_count;
  logic start0, abort0;
  logic mic_clk0, chain_flush0, busy0, done0, overflow0;
  logic [CNT_W-1:0] sample_count0;

  pdm_capture_controller_if bus ();
  pdm_capture_controller_if bus0 ();

  pdm_capture_controller #(.CLK_DIV(CLK_DIV), .WARMUP_LEN(WL), .CAPTURE_LEN(CL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .mic_clk(mic_clk), .chain_flush(chain_flush), .busy(busy), .done(done),
    .overflow(overflow), .sample_count(sample_count));

  pdm_capture_controller #(.CLK_DIV(CLK_DIV), .WARMUP_LEN(0), .CAPTURE_LEN(CL), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .bus(bus0),
    .mic_clk(mic_clk0), .chain_flush(chain_flush0), .busy(busy0), .done(done0),
    .overflow(overflow0), .sample_count(sample_count0));

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_done = 0;
  pcm8_t acc_q[$];

  // Behavioural model: phase 0 idle, 1 flush, 2 warm-up, 3 capture, 4 drain.
  int    md_ph = 0, md_cyc = 0, md_warm = 0, md_cnt = 0, md_t = 0;
  bit    md_ovf = 0, md_hold = 0, md_done = 0;
  pcm8_t md_data = 0;

  task automatic model_step();
    int prev;
    prev    = md_ph;
    md_done = 0;
    if (rst) begin
      md_ph = 0; md_cyc = 0; md_warm = 0; md_cnt = 0; md_t = 0;
      md_ovf = 0; md_hold = 0; md_data = 0;
    end else if (abort) begin
      md_ph = 0; md_hold = 0;
    end else begin
      case (md_ph)
        0: if (start) begin md_ph = 1; md_cyc = 0; md_ovf = 0; md_cnt = 0; end
        1: begin
          md_cyc++;
          if (md_cyc == CLK_DIV) begin md_ph = (WL == 0) ? 3 : 2; md_warm = 0; end
        end
        2: if (bus.in_valid) begin md_warm++; if (md_warm == WL) md_ph = 3; end
        3: begin
          if (bus.in_valid && (!md_hold || bus.m_ready)) begin
            md_hold = 1; md_data = bus.in_data; md_cnt++;
            if (md_cnt == CL) md_ph = 4;
          end else if (bus.in_valid) md_ovf = 1;
          else if (md_hold && bus.m_ready) md_hold = 0;
        end
        4: begin
          if (md_hold && bus.m_ready) md_hold = 0;
          else if (!md_hold) begin md_ph = 0; md_done = 1; end
        end
        default: md_ph = 0;
      endcase
    end
    if (md_ph >= 1 && md_ph <= 3) md_t = (prev == 0) ? 0 : md_t + 1;
  endtask

  task automatic tick();
    if (bus.m_valid && bus.m_ready) acc_q.push_back(bus.m_data);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (done) n_done++;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic strobe(input pcm8_t d);
    bus.in_valid = 1'b1; bus.in_data = d; tick();
    bus.in_valid = 1'b0; tick();
  endtask

  task automatic to_capture();
    pulse_start();
    repeat (CLK_DIV + 1) tick();
    strobe(pcm8_t'($urandom));
    strobe(pcm8_t'($urandom));
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 40 && busy; c++) tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_timeout busy=%0b want 0", name, busy); end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    got = {busy, mic_clk, chain_flush, bus.m_valid, bus.m_data, done, overflow, sample_count};
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", got); end
    n_cmp++;
    if ({busy0, bus0.m_valid, mic_clk0, sample_count0} !== '0) begin
      n_bad++; $display("FAIL reset_dut0 got %b%b%b %0d want zeros", busy0, bus0.m_valid, mic_clk0, sample_count0);
    end
  endtask

  task automatic test_normal();
    bus.m_ready = 1'b1; acc_q.delete(); n_done = 0;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      repeat (7) tick();
      bus.in_valid = 1'b1; bus.in_data = pcm8_t'(8'h10 + k); tick(); bus.in_valid = 1'b0;
    end
    wait_idle("normal");
    n_cmp++;
    if (acc_q.size() != 4) begin n_bad++; $display("FAIL normal_count got %0d want 4", acc_q.size()); end
    for (int i = 0; i < acc_q.size() && i < 4; i++) begin
      n_cmp++;
      if (acc_q[i] !== pcm8_t'(8'h12 + i)) begin
        n_bad++; $display("FAIL normal_data[%0d] got %h want %h", i, acc_q[i], 8'h12 + i);
      end
    end
    n_cmp++;
    if (n_done != 1) begin n_bad++; $display("FAIL normal_done got %0d want 1", n_done); end
    n_cmp++;
    if ({overflow, sample_count} !== {1'b0, 16'd4}) begin
      n_bad++; $display("FAIL normal_status got ovf=%0b cnt=%0d want 0/4", overflow, sample_count);
    end
  endtask

  task automatic test_backpressure();
    pcm8_t a, b;
    a = pcm8_t'($urandom); b = ~a;
    bus.m_ready = 1'b0;
    to_capture();
    bus.in_valid = 1'b1; bus.in_data = a; tick();
    bus.in_data = b; tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.m_valid, bus.m_data} !== {1'b1, a}) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v=%0b d=%h want 1/%h", i, bus.m_valid, bus.m_data, a);
      end
      tick();
    end
    n_cmp++;
    if ({overflow, sample_count} !== {1'b1, 16'd1}) begin
      n_bad++; $display("FAIL bp_status got ovf=%0b cnt=%0d want 1/1", overflow, sample_count);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if ({busy, bus.m_valid, overflow} !== 3'b001) begin
      n_bad++; $display("FAIL bp_abort got busy=%0b v=%0b ovf=%0b want 0/0/1", busy, bus.m_valid, overflow);
    end
  endtask

  task automatic test_drain_wait();
    pcm8_t last;
    bus.m_ready = 1'b1;
    to_capture();
    repeat (3) strobe(pcm8_t'($urandom));
    bus.m_ready = 1'b0;
    last = pcm8_t'($urandom);
    strobe(last);
    acc_q.delete(); n_done = 0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({busy, done, mic_clk, bus.m_valid} !== 4'b1001) begin
        n_bad++; $display("FAIL drain_wait[%0d] got busy/done/mic/v=%b want 1001", i, {busy, done, mic_clk, bus.m_valid});
      end
      tick();
    end
    bus.m_ready = 1'b1;
    wait_idle("drain");
    n_cmp++;
    if (done !== 1'b1 || n_done != 1) begin
      n_bad++; $display("FAIL drain_done got done=%0b pulses=%0d want 1/1", done, n_done);
    end
    n_cmp++;
    if (acc_q.size() != 1 || acc_q[0] !== last) begin
      n_bad++; $display("FAIL drain_data got n=%0d want 1 sample %h", acc_q.size(), last);
    end
  endtask

  task automatic test_abort();
    pcm8_t exp[4];
    bus.m_ready = 1'b1; n_done = 0;
    to_capture();
    strobe(pcm8_t'($urandom)); strobe(pcm8_t'($urandom));
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if ({busy, bus.m_valid, mic_clk, chain_flush} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_idle got %b want 0000", {busy, bus.m_valid, mic_clk, chain_flush});
    end
    n_cmp++;
    if (sample_count !== 16'd2) begin n_bad++; $display("FAIL abort_count got %0d want 2", sample_count); end
    repeat (3) tick();
    n_cmp++;
    if (n_done != 0) begin n_bad++; $display("FAIL abort_done got %0d want 0", n_done); end
    pulse_start();
    n_cmp++;
    if ({busy, sample_count} !== {1'b1, 16'd0}) begin
      n_bad++; $display("FAIL abort_restart got busy=%0b cnt=%0d want 1/0", busy, sample_count);
    end
    repeat (CLK_DIV + 1) tick();
    acc_q.delete();
    strobe(pcm8_t'($urandom)); strobe(pcm8_t'($urandom));
    for (int i = 0; i < 4; i++) begin exp[i] = pcm8_t'($urandom); strobe(exp[i]); end
    wait_idle("abort");
    n_cmp++;
    if (sample_count !== 16'd4 || n_done != 1 || acc_q.size() != 4) begin
      n_bad++; $display("FAIL abort_recapture got cnt=%0d done=%0d n=%0d want 4/1/4", sample_count, n_done, acc_q.size());
    end
    for (int i = 0; i < acc_q.size() && i < 4; i++) begin
      n_cmp++;
      if (acc_q[i] !== exp[i]) begin n_bad++; $display("FAIL abort_data[%0d] got %h want %h", i, acc_q[i], exp[i]); end
    end
  endtask

  task automatic test_clocking();
    int flush_cycles;
    flush_cycles = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (chain_flush) flush_cycles++;
      n_cmp++;
      if (chain_flush !== (i < CLK_DIV) || mic_clk !== ((i % CLK_DIV) >= CLK_DIV / 2)) begin
        n_bad++; $display("FAIL clocking[%0d] got flush=%0b mic=%0b want %0b/%0b", i, chain_flush, mic_clk,
                          i < CLK_DIV, (i % CLK_DIV) >= CLK_DIV / 2);
      end
      start = (i == 5);
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (flush_cycles != CLK_DIV) begin n_bad++; $display("FAIL clocking_flush got %0d want %0d", flush_cycles, CLK_DIV); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [31:0] got;
    pulse_start();
    repeat (CLK_DIV + 1) tick();
    strobe(pcm8_t'($urandom));
    rst = 1'b1; tick(); rst = 1'b0;
    got = {busy, mic_clk, chain_flush, bus.m_valid, bus.m_data, done, overflow, sample_count};
    n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL rst_mid got %h want 0", got); end
  endtask

  task automatic test_warmup0();
    pcm8_t x;
    x = pcm8_t'($urandom);
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick(); tick();
    bus0.in_valid = 1'b1; bus0.in_data = ~x; tick(); bus0.in_valid = 1'b0;
    n_cmp++;
    if ({bus0.m_valid, chain_flush0} !== 2'b01) begin
      n_bad++; $display("FAIL wl0_flush_ignore got v=%0b flush=%0b want 0/1", bus0.m_valid, chain_flush0);
    end
    tick();
    bus0.in_valid = 1'b1; bus0.in_data = x; tick(); bus0.in_valid = 1'b0;
    n_cmp++;
    if ({bus0.m_valid, bus0.m_data, sample_count0} !== {1'b1, x, 16'd1}) begin
      n_bad++; $display("FAIL wl0_capture got v=%0b d=%h cnt=%0d want 1/%h/1", bus0.m_valid, bus0.m_data, sample_count0, x);
    end
    abort0 = 1'b1; tick(); abort0 = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] got, exp;
    for (int run = 0; run < 3; run++) begin
      pulse_start();
      for (int c = 0; c < 400 && md_ph != 0; c++) begin
        bus.in_valid = ($urandom_range(0, 2) == 0);
        bus.in_data  = pcm8_t'($urandom);
        bus.m_ready  = ($urandom_range(0, 3) != 0);
        tick();
        got = {bus.m_valid, busy, done, overflow, mic_clk, chain_flush};
        exp = {md_hold, md_ph != 0, md_done, md_ovf,
               (md_ph >= 1 && md_ph <= 3) && ((md_t % CLK_DIV) >= CLK_DIV / 2), md_ph == 1};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL rand_ctrl run%0d cyc%0d got %b want %b", run, c, got, exp); end
        n_cmp++;
        if (sample_count !== 16'(md_cnt) || (md_hold && bus.m_data !== md_data)) begin
          n_bad++; $display("FAIL rand_data run%0d cyc%0d got cnt=%0d d=%h want %0d/%h", run, c, sample_count, bus.m_data, md_cnt, md_data);
        end
      end
      bus.in_valid = 1'b0;
      n_cmp++;
      if (md_ph != 0) begin n_bad++; $display("FAIL rand_timeout run%0d phase=%0d want 0", run, md_ph); end
      repeat (2) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.m_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.m_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_normal();
    test_backpressure();
    test_drain_wait();
    test_abort();
    test_clocking();
    test_rst_mid();
    test_warmup0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
